// File: rtl/blowfish_mode_pkg.sv
// Shared types for the Blowfish mode-of-operation controller.
// Encodings are fixed explicitly so they match the legacy state/mode values.
package blowfish_mode_pkg;

    typedef enum logic [1:0] {
        MODE_ECB  = 2'd0,
        MODE_CBC  = 2'd1,
        MODE_CTR  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } state_e;

endpackage

// File: rtl/blowfish_ctr_inc.sv
// Wrap-around increment of the low CTR_W bits of a BLOCK_W word;
// the bits above the counter field pass through untouched.
module blowfish_ctr_inc #(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned CTR_W   = 64
) (
    input  logic [BLOCK_W-1:0] word_i,
    output logic [BLOCK_W-1:0] word_o
);

    logic [CTR_W-1:0] low;

    assign low = word_i[CTR_W-1:0] + CTR_W'(1);

    generate
        if (CTR_W < BLOCK_W) begin : g_split
            assign word_o = {word_i[BLOCK_W-1:CTR_W], low};
        end else begin : g_full
            assign word_o = low;
        end
    endgenerate

endmodule

// File: rtl/blowfish_mode_ctrl.sv
// ECB/CBC/CTR mode controller: streams host blocks one at a time through an
// external block core over a start/done handshake, holding chain/counter state.
module blowfish_mode_ctrl
    import blowfish_mode_pkg::*;
#(
    parameter int unsigned BLOCK_W = 128,
    parameter int unsigned CTR_W   = 64
) (
    input  logic               Clk,
    input  logic               RstN,
    input  logic               Enable,
    input  logic               cfg_start,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_encrypt,
    input  logic [BLOCK_W-1:0] cfg_iv,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_last,
    output logic               core_start,
    output logic               core_encrypt,
    output logic [BLOCK_W-1:0] core_data,
    input  logic [BLOCK_W-1:0] core_result,
    input  logic               core_done
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic               enc_q, enc_d;
    logic [BLOCK_W-1:0] chain_q, chain_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic               last_q, last_d;
    logic [BLOCK_W-1:0] core_in_q, core_in_d;
    logic [BLOCK_W-1:0] out_q, out_d;
    logic [BLOCK_W-1:0] chain_inc;

    blowfish_ctr_inc #(
        .BLOCK_W (BLOCK_W),
        .CTR_W   (CTR_W)
    ) u_ctr_inc (
        .word_i (chain_q),
        .word_o (chain_inc)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        enc_d     = enc_q;
        chain_d   = chain_q;
        data_d    = data_q;
        last_d    = last_q;
        core_in_d = core_in_q;
        out_d     = out_q;

        if (!Enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_start && (mode_e'(cfg_mode) != MODE_RSVD)) begin
                        mode_d  = mode_e'(cfg_mode);
                        enc_d   = cfg_encrypt;
                        chain_d = cfg_iv;
                        state_d = READY;
                    end
                end
                READY: begin
                    if (in_valid) begin
                        data_d = in_data;
                        last_d = in_last;
                        case (mode_q)
                            MODE_CBC: core_in_d = enc_q ? (in_data ^ chain_q) : in_data;
                            MODE_CTR: core_in_d = chain_q;
                            default:  core_in_d = in_data;
                        endcase
                        state_d = ISSUE;
                    end
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    if (core_done) begin
                        case (mode_q)
                            MODE_CBC: out_d = enc_q ? core_result : (core_result ^ chain_q);
                            MODE_CTR: out_d = data_q ^ core_result;
                            default:  out_d = core_result;
                        endcase
                        state_d = OUT;
                    end
                end
                OUT: begin
                    // Chain advances only here so backpressure cannot disturb it.
                    if (out_ready) begin
                        case (mode_q)
                            MODE_CBC: chain_d = enc_q ? out_q : data_q;
                            MODE_CTR: chain_d = chain_inc;
                            default:  chain_d = chain_q;
                        endcase
                        state_d = last_q ? IDLE : READY;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q   <= IDLE;
            mode_q    <= MODE_ECB;
            enc_q     <= 1'b0;
            chain_q   <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            core_in_q <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            enc_q     <= enc_d;
            chain_q   <= chain_d;
            data_q    <= data_d;
            last_q    <= last_d;
            core_in_q <= core_in_d;
            out_q     <= out_d;
        end
    end

    assign in_ready     = Enable && (state_q == READY);
    assign core_start   = Enable && (state_q == ISSUE);
    assign out_valid    = Enable && (state_q == OUT);
    assign out_data     = out_q;
    assign out_last     = (state_q == OUT) && last_q;
    assign core_data    = core_in_q;
    assign core_encrypt = ((state_q == ISSUE) || (state_q == WAIT)) &&
                          ((mode_q == MODE_CTR) || enc_q);
    assign cfg_err      = Enable && (state_q == IDLE) && cfg_start &&
                          (mode_e'(cfg_mode) == MODE_RSVD);

endmodule

// File: tb/tb_blowfish_mode_ctrl.sv
// Scoreboard bench for blowfish_mode_ctrl with an XOR stub core (3-cycle latency).
module tb_blowfish_mode_ctrl;
    import blowfish_mode_pkg::*;

    localparam logic [127:0] K = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

    logic         Clk = 1'b0;
    logic         RstN = 1'b0;
    logic         Enable = 1'b0;
    logic         cfg_start = 1'b0;
    logic [1:0]   cfg_mode = 2'd0;
    logic         cfg_encrypt = 1'b0;
    logic [127:0] cfg_iv = '0;
    logic         cfg_err;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         out_last;
    logic         core_start;
    logic         core_encrypt;
    logic [127:0] core_data;
    logic [127:0] core_result;
    logic         core_done;

    always #5 Clk = ~Clk;

    blowfish_mode_ctrl #(
        .BLOCK_W (128),
        .CTR_W   (64)
    ) dut (
        .Clk          (Clk),
        .RstN         (RstN),
        .Enable       (Enable),
        .cfg_start    (cfg_start),
        .cfg_mode     (cfg_mode),
        .cfg_encrypt  (cfg_encrypt),
        .cfg_iv       (cfg_iv),
        .cfg_err      (cfg_err),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .core_start   (core_start),
        .core_encrypt (core_encrypt),
        .core_data    (core_data),
        .core_result  (core_result),
        .core_done    (core_done)
    );

    // Stub core: result = data ^ K, done three cycles after start.
    logic [2:0]   sr = 3'b000;
    logic [127:0] lat = '0;
    always @(posedge Clk) begin
        sr <= {sr[1:0], core_start};
        if (core_start) lat <= core_data;
    end
    assign core_done   = sr[2];
    assign core_result = lat ^ K;

    typedef struct packed {
        logic [127:0] d;
        logic         l;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           fails = 0;
    int           ov_cnt = 0;
    logic         exp_cenc = 1'b0;
    logic         prev_start = 1'b0;
    logic         held = 1'b0;
    logic [127:0] held_d = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL %s: timed out, expected event never occurred", name);
    endtask

    // Monitor: pops scoreboard on every output handshake.
    always @(negedge Clk) begin
        if (RstN) begin
            if (core_start) begin
                chk("core_encrypt", core_encrypt, exp_cenc);
                chk("core_start_single_cycle", prev_start, 0);
            end
            prev_start = core_start;
            if (out_valid) ov_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", out_last, e.l);
                end
            end
            if (out_valid && !out_ready) begin
                if (held) begin
                    chk("bp_out_data_stable", out_data, held_d);
                    chk("bp_in_ready_low", in_ready, 0);
                end
                held = 1'b1;
                held_d = out_data;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic configure(input logic [1:0] m, input logic e, input logic [127:0] iv);
        @(posedge Clk); #1;
        cfg_start = 1'b1;
        cfg_mode = m;
        cfg_encrypt = e;
        cfg_iv = iv;
        exp_cenc = (m == 2'd2) ? 1'b1 : e;
        @(posedge Clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input logic l);
        bit ok = 0;
        @(posedge Clk); #1;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge Clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!ok) timeout("send_accept");
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (sb.size() == 0 && dut.state_q == IDLE) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout(name);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int  ovs;
        bit  ok;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_core_data", core_data, 0);
        chk("rst_core_encrypt", core_encrypt, 0);
        chk("rst_chain", dut.chain_q, 0);
        chk("rst_state", dut.state_q, IDLE);
        @(posedge Clk); #1;
        RstN = 1'b1;
        Enable = 1'b1;

        // in_valid while IDLE is not accepted
        in_valid = 1'b1;
        @(negedge Clk);
        chk("idle_in_ready", in_ready, 0);
        @(posedge Clk); #1;
        in_valid = 1'b0;

        // ECB encrypt single block
        configure(2'd0, 1'b1, '0);
        sb.push_back('{128'hFFFF0000_FFFF0000_FFFF0000_FFFF0001, 1'b1});
        send(128'h1, 1'b1);
        wait_idle("ecb_done");

        // CBC encrypt, IV=A0
        configure(2'd1, 1'b1, 128'hA0);
        sb.push_back('{128'hFFFF0000_FFFF0000_FFFF0000_FFFF00A1, 1'b0});
        sb.push_back('{128'hA3, 1'b1});
        send(128'h1, 1'b0);
        send(128'h2, 1'b1);
        wait_idle("cbc_enc_done");

        // CBC decrypt of the same ciphertext
        configure(2'd1, 1'b0, 128'hA0);
        sb.push_back('{128'h1, 1'b0});
        sb.push_back('{128'h2, 1'b1});
        send(128'hFFFF0000_FFFF0000_FFFF0000_FFFF00A1, 1'b0);
        send(128'hA3, 1'b1);
        wait_idle("cbc_dec_done");

        // CTR with low-field wrap; core_encrypt forced high despite decrypt config
        configure(2'd2, 1'b0, 128'h1234_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        sb.push_back('{128'hEDCB_0000_FFFF_0000_0000_FFFF_0000_FFFF, 1'b0});
        sb.push_back('{128'hEDCB_0000_FFFF_0000_FFFF_0000_FFFF_0000, 1'b1});
        send('0, 1'b0);
        send('0, 1'b1);
        wait_idle("ctr_done");

        // CBC encrypt with 5 cycles of output backpressure on the first block
        configure(2'd1, 1'b1, 128'h10);
        out_ready = 1'b0;
        sb.push_back('{128'hFFFF0000_FFFF0000_FFFF0000_FFFF0015, 1'b0});
        sb.push_back('{128'h13, 1'b1});
        send(128'h5, 1'b0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("bp_out_valid");
        repeat (5) @(posedge Clk);
        #1;
        out_ready = 1'b1;
        send(128'h6, 1'b1);
        wait_idle("bp_done");

        // Abort during WAIT; late core_done must be ignored
        configure(2'd0, 1'b1, '0);
        ovs = ov_cnt;
        send(128'h77, 1'b0);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (core_start) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("abort_core_start");
        @(posedge Clk); #1;
        Enable = 1'b0;
        repeat (5) @(negedge Clk);
        chk("abort_no_out_valid", ov_cnt, ovs);
        chk("abort_state_idle", dut.state_q, IDLE);
        chk("abort_in_ready", in_ready, 0);
        @(posedge Clk); #1;
        Enable = 1'b1;
        repeat (3) @(negedge Clk);
        chk("abort_late_done_ignored", ov_cnt, ovs);

        // Clean session after the abort (ECB decrypt)
        configure(2'd0, 1'b0, '0);
        sb.push_back('{128'hFFFF0000_FFFF0000_FFFF0000_FFFF0033, 1'b1});
        send(128'h33, 1'b1);
        wait_idle("post_abort_done");

        // Reserved mode: single-cycle cfg_err, stay IDLE
        @(posedge Clk); #1;
        cfg_start = 1'b1;
        cfg_mode = 2'd3;
        @(negedge Clk);
        chk("cfg_err_pulse", cfg_err, 1);
        @(posedge Clk); #1;
        cfg_start = 1'b0;
        @(negedge Clk);
        chk("cfg_err_single_cycle", cfg_err, 0);
        chk("rsvd_state_idle", dut.state_q, IDLE);
        chk("rsvd_in_ready", in_ready, 0);

        repeat (2) @(negedge Clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
